// File: rtl/ram_access_ctrl_pkg.sv
// Shared op codes, FSM state encoding and sizing helper for ram_access_ctrl
// and its benches.
package ram_access_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WRITE,
    ST_READ,
    ST_CLEAR,
    ST_VERIFY,
    ST_RESP
  } state_e;

  // Counter holds (cycles-1) at most, so it needs clog2(max cycles) bits.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Command/response stream plus RAM pin bundle for ram_access_ctrl.
// slave = controller view, master = sequencer/RAM environment view.
interface ram_access_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 1
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_clear;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, mem_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_rw, mem_addr, mem_wdata, mem_clear
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, mem_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_rw, mem_addr, mem_wdata, mem_clear
  );
endinterface

// File: rtl/rac_cycle_cnt.sv
// Loadable down-counter; zero_o marks the last cycle of a timed phase.
module rac_cycle_cnt #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/ram_access_ctrl.sv
// Command-stream initiator for word-organised RAMs (mem2x8 family).
// Optional WRITE_VERIFY_EN adds a read-back VERIFY phase after every write.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 1,
  parameter int unsigned WR_CYCLES  = 1,
  parameter int unsigned RD_WAIT    = 1,
  parameter int unsigned CLR_CYCLES = 1
) (
  input logic               clk,
  input logic               clear_n,
  ram_access_ctrl_if.slave  bus
);
  localparam int unsigned CNT_W = cnt_width(WR_CYCLES, RD_WAIT, CLR_CYCLES);
  localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LD  = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] CLR_LD = CNT_W'(CLR_CYCLES - 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_zero;
  logic              cmd_fire;
  op_e               cmd_op;

  assign cmd_op   = op_e'(bus.cmd_op);
  assign cmd_fire = bus.cmd_valid && (state_q == ST_IDLE);

  rac_cycle_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (clear_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_fire) state_d = ST_SETUP;
      ST_SETUP: begin
        case (op_q)
          OP_WRITE: state_d = ST_WRITE;
          OP_READ:  state_d = ST_READ;
          OP_CLEAR: state_d = ST_CLEAR;
          default:  state_d = ST_RESP;
        endcase
      end
`ifdef WRITE_VERIFY_EN
      ST_WRITE: if (cnt_zero) state_d = ST_VERIFY;
      ST_VERIFY: if (cnt_zero) state_d = ST_RESP;
`else
      ST_WRITE: if (cnt_zero) state_d = ST_RESP;
`endif
      ST_READ, ST_CLEAR: if (cnt_zero) state_d = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from state_q so reset drops them without a clock.
  always_comb begin
    bus.cmd_ready = (state_q == ST_IDLE);
    bus.rsp_valid = (state_q == ST_RESP);
    bus.mem_rw    = (state_q == ST_WRITE);
    bus.mem_clear = (state_q == ST_CLEAR);
    cnt_load      = (state_d != state_q);
    cnt_val       = '0;
    case (state_d)
      ST_WRITE:           cnt_val = WR_LD;
      ST_READ, ST_VERIFY: cnt_val = RD_LD;
      ST_CLEAR:           cnt_val = CLR_LD;
      default:            cnt_val = '0;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          op_d    = cmd_op;
          rdata_d = '0;
          err_d   = (cmd_op == OP_RSVD);
          // Reserved ops leave the RAM pins untouched.
          if (cmd_op != OP_RSVD) begin
            addr_d  = bus.cmd_addr;
            wdata_d = bus.cmd_wdata;
          end
        end
      end
      ST_READ: if (cnt_zero) rdata_d = bus.mem_rdata;
`ifdef WRITE_VERIFY_EN
      ST_VERIFY: begin
        if (cnt_zero) begin
          rdata_d = bus.mem_rdata;
          err_d   = (bus.mem_rdata != wdata_q);
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench: command-level RAM model plus cycle-offset timing
// expectations, checked every cycle, with directed and random commands.
`timescale 1ns/1ps
module tb_ram_access_ctrl;
  import ram_access_ctrl_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 1;
  localparam int unsigned WR = 3;
  localparam int unsigned RD = 2;
  localparam int unsigned CL = 2;
`ifdef WRITE_VERIFY_EN
  localparam int WR_LAT = 2 + WR + RD;
`else
  localparam int WR_LAT = 2 + WR;
`endif

  logic clk = 1'b0;
  logic clear_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  ram_access_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ram_access_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .WR_CYCLES(WR), .RD_WAIT(RD), .CLR_CYCLES(CL)
  ) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM attached to the controller pins; stuck_mask models a read-path fault.
  logic [DW-1:0] ram [2];
  logic [DW-1:0] stuck_mask = '1;
  always @(posedge clk) begin
    if (bus.mem_clear) begin
      ram[0] <= '0;
      ram[1] <= '0;
    end else if (bus.mem_rw) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = ram[bus.mem_addr] & stuck_mask;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Behavioural model: memory contents after each completed command, and
  // the in-flight command with its accept cycle.
  logic [DW-1:0] model [2];
  bit            infl = 1'b0;
  int            t_acc = 0;
  int            m_lat = 0;
  op_e           m_op = OP_READ;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_err = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wdata = '0;

  always @(negedge clk) begin
    int   d;
    logic e_rw, e_clr, e_rv;
    if (!clear_n) begin
      infl = 1'b0;
      last_addr = '0;
      last_wdata = '0;
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
      chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
      chk("rst_mem_rw",    32'(bus.mem_rw),    32'd0);
      chk("rst_mem_clear", 32'(bus.mem_clear), 32'd0);
      chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    end else begin
      d     = cyc - t_acc;
      e_rw  = infl && (m_op == OP_WRITE) && (d >= 2) && (d < 2 + int'(WR));
      e_clr = infl && (m_op == OP_CLEAR) && (d >= 2) && (d < 2 + int'(CL));
      e_rv  = infl && (d >= m_lat);
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(!infl));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
      chk("mem_rw",    32'(bus.mem_rw),    32'(e_rw));
      chk("mem_clear", 32'(bus.mem_clear), 32'(e_clr));
      chk("mem_addr",  32'(bus.mem_addr),  32'(last_addr));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(last_wdata));
      if (e_rv) begin
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rdata));
        chk("rsp_err",   32'(bus.rsp_err),   32'(m_err));
      end
      if (e_rv && bus.rsp_ready) begin
        if (m_op == OP_WRITE) model[m_addr] = m_wdata;
        if (m_op == OP_CLEAR) begin
          model[0] = '0;
          model[1] = '0;
        end
        infl = 1'b0;
      end else if (!infl && bus.cmd_valid) begin
        m_op    = op_e'(bus.cmd_op);
        m_addr  = bus.cmd_addr;
        m_wdata = bus.cmd_wdata;
        t_acc   = cyc;
        m_rdata = '0;
        m_err   = 1'b0;
        case (m_op)
          OP_READ: begin
            m_rdata = model[m_addr] & stuck_mask;
            m_lat   = 2 + int'(RD);
          end
          OP_WRITE: begin
            m_lat = WR_LAT;
`ifdef WRITE_VERIFY_EN
            m_rdata = m_wdata & stuck_mask;
            m_err   = (m_rdata != m_wdata);
`endif
          end
          OP_CLEAR: m_lat = 2 + int'(CL);
          default: begin
            m_lat = 2;
            m_err = 1'b1;
          end
        endcase
        if (m_op != OP_RSVD) begin
          last_addr  = m_addr;
          last_wdata = m_wdata;
        end
        infl = 1'b1;
      end
    end
  end

  // Width of the most recent completed mem_rw / mem_clear pulse.
  int rw_run = 0, rw_last = 0, cl_run = 0, cl_last = 0;
  always @(negedge clk) begin
    if (bus.mem_rw) rw_run++;
    else if (rw_run != 0) begin rw_last = rw_run; rw_run = 0; end
    if (bus.mem_clear) cl_run++;
    else if (cl_run != 0) begin cl_last = cl_run; cl_run = 0; end
  end

  // hold < 0: rsp_ready already high when the response appears.
  // junk: keep cmd_valid high with other fields while busy.
  task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input int hold, input bit junk,
                        output logic [DW-1:0] rd, output logic er, output int lat);
    int t0;
    int n;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.rsp_ready = (hold < 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.cmd_ready && n < 50);
    chk("accept_timeout", 32'(bus.cmd_ready), 32'd1);
    t0 = cyc;
    @(posedge clk); #1;
    if (junk) begin
      bus.cmd_op    = 2'($urandom);
      bus.cmd_addr  = AW'($urandom);
      bus.cmd_wdata = DW'($urandom);
    end else begin
      bus.cmd_valid = 1'b0;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 50);
    chk("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
    lat = cyc - t0;
    rd  = bus.rsp_rdata;
    er  = bus.rsp_err;
    if (hold >= 0) begin
      repeat (hold) @(negedge clk);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
  endtask

  logic [DW-1:0] rd;
  logic          er;
  int            lat;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    #2 clear_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 clear_n = 1'b1;

    do_cmd(2'b10, 1'b0, 8'h00, 0, 1'b0, rd, er, lat);

    do_cmd(2'b01, 1'b0, 8'hCE, 0, 1'b0, rd, er, lat);
    chk("wr_lat", 32'(lat), 32'(WR_LAT));
    chk("wr_pulse", 32'(rw_last), 32'd3);
    do_cmd(2'b00, 1'b0, 8'h00, 0, 1'b0, rd, er, lat);
    chk("rd0_data", 32'(rd), 32'hCE);
    chk("rd0_err", 32'(er), 32'd0);
    chk("rd_lat", 32'(lat), 32'd4);

    do_cmd(2'b01, 1'b1, 8'hBC, -1, 1'b0, rd, er, lat);
    do_cmd(2'b00, 1'b0, 8'h00, -1, 1'b0, rd, er, lat);
    chk("alias_rd0", 32'(rd), 32'hCE);
    do_cmd(2'b00, 1'b1, 8'h00, 0, 1'b0, rd, er, lat);
    chk("alias_rd1", 32'(rd), 32'hBC);

    do_cmd(2'b10, 1'b0, 8'h00, 0, 1'b0, rd, er, lat);
    chk("clr_lat", 32'(lat), 32'd4);
    chk("clr_pulse", 32'(cl_last), 32'd2);
    do_cmd(2'b00, 1'b0, 8'h00, 0, 1'b0, rd, er, lat);
    chk("clr_rd0", 32'(rd), 32'h00);
    do_cmd(2'b00, 1'b1, 8'h00, 0, 1'b0, rd, er, lat);
    chk("clr_rd1", 32'(rd), 32'h00);

    do_cmd(2'b01, 1'b0, 8'h3C, 5, 1'b1, rd, er, lat);
    do_cmd(2'b00, 1'b0, 8'h00, 5, 1'b1, rd, er, lat);
    chk("hold_rd0", 32'(rd), 32'h3C);

    begin : abort_seq
      int n;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b01;
      bus.cmd_addr  = 1'b0;
      bus.cmd_wdata = 8'h5A;
      @(negedge clk);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      n = 0;
      while (!bus.mem_rw && n < 20) begin @(posedge clk); #1; n++; end
      chk("abort_rw_seen", 32'(bus.mem_rw), 32'd1);
      #1 clear_n = 1'b0;
      #1;
      chk("abort_rw_drop", 32'(bus.mem_rw), 32'd0);
      chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
      chk("abort_addr", 32'(bus.mem_addr), 32'd0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1 clear_n = 1'b1;
    end
    do_cmd(2'b00, 1'b0, 8'h00, 0, 1'b0, rd, er, lat);
    chk("abort_rd0", 32'(rd), 32'h3C);

    do_cmd(2'b11, 1'b1, 8'hFF, 0, 1'b0, rd, er, lat);
    chk("rsvd_err", 32'(er), 32'd1);
    chk("rsvd_rdata", 32'(rd), 32'd0);
    chk("rsvd_lat", 32'(lat), 32'd2);
`ifdef WRITE_VERIFY_EN
    stuck_mask = 8'hFE;
    do_cmd(2'b01, 1'b1, 8'h01, 0, 1'b0, rd, er, lat);
    chk("verify_err", 32'(er), 32'd1);
    chk("verify_rdata", 32'(rd), 32'h00);
    stuck_mask = '1;
`endif

    for (int i = 0; i < 150; i++) begin
      int hold;
      hold = int'($urandom_range(4, 0)) - 1;
      repeat ($urandom_range(2, 0)) @(posedge clk);
      do_cmd(2'($urandom), AW'($urandom), DW'($urandom), hold, 1'($urandom),
             rd, er, lat);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
